// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - mult/div issue, occupancy tracking and D-stage HI/LO hazard stall
module md_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic        ex_valid,
    input  logic        md_busy_in,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        busy_o,
    output logic        stall_d,
    output logic        proto_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [3:0] MUL_LOAD    = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD    = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        proto_err_q, proto_err_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    // High during the first busy cycle, where the unit's own busy flag may still lag.
    logic        first_q, first_d;

    logic ex_is_start;
    logic id_is_md;
    logic id_is_start;
    logic issue_while_busy;
    logic busy_mismatch;

    // Bits of the instruction words that the decoder does not look at.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr[25:6], ex_instr[25:6]};

    // mult/multu/div/divu: SPECIAL with funct 0110xx.
    function automatic logic dec_start(input logic [31:0] instr);
        return (instr[31:26] == OPC_SPECIAL) && (instr[5:2] == 4'b0110);
    endfunction

    // mfhi/mthi/mflo/mtlo: SPECIAL with funct 0100xx.
    function automatic logic dec_hilo(input logic [31:0] instr);
        return (instr[31:26] == OPC_SPECIAL) && (instr[5:2] == 4'b0100);
    endfunction

    assign ex_is_start = dec_start(ex_instr);
    assign id_is_start = dec_start(id_instr);
    assign id_is_md    = id_is_start | dec_hilo(id_instr);

    // Next-state, issue and hazard decisions; every output defaulted first.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        first_d          = 1'b0;
        md_start         = 1'b0;
        md_op            = ex_instr[1:0];
        busy_o           = 1'b0;
        stall_d          = 1'b0;
        issue_while_busy = 1'b0;
        busy_mismatch    = 1'b0;
        proto_err_d      = proto_err_q;
        stall_cnt_d      = stall_cnt_q;

        if (!reset) begin
            busy_o   = (state_q != ST_IDLE);
            md_start = ex_valid && ex_is_start && (state_q == ST_IDLE);
            stall_d  = id_is_md && (md_start || busy_o);

            // An E-stage start while occupied is dropped and flagged.
            issue_while_busy = ex_valid && ex_is_start && (state_q != ST_IDLE);
            // Unit busy must track ours once past the first busy cycle.
            busy_mismatch    = busy_o && !first_q && (busy_o != md_busy_in);

            if (issue_while_busy || busy_mismatch) begin
                proto_err_d = 1'b1;
            end

            if (stall_d) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end

            if (md_start) begin
                first_d = 1'b1;
                if (ex_instr[1]) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_LOAD;
                end else begin
                    state_d = ST_MUL;
                    cnt_d   = MUL_LOAD;
                end
            end else if (state_q != ST_IDLE) begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end
    end

    // State, occupancy counter, sticky error and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            first_q     <= 1'b0;
            proto_err_q <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            proto_err_q <= proto_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign proto_err = proto_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - directed scoreboard bench for md_issue_ctrl
module tb_md_issue_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MULT  = 32'h0085_0018;
    localparam logic [31:0] MULTU = 32'h0085_0019;
    localparam logic [31:0] DIVI  = 32'h0085_001A;
    localparam logic [31:0] MFLO  = 32'h0000_1012;
    localparam logic [31:0] ADDU  = 32'h0085_1021;

    logic        clk;
    logic        reset;
    logic [31:0] id_instr;
    logic [31:0] ex_instr;
    logic        ex_valid;
    logic        md_busy_in;
    logic        md_start;
    logic [1:0]  md_op;
    logic        busy_o;
    logic        stall_d;
    logic        proto_err;
    logic [31:0] stall_cnt;

    typedef struct {
        logic        start;
        logic [1:0]  op;
        logic        busy;
        logic        stall;
        logic        perr;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    md_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_instr   (id_instr),
        .ex_instr   (ex_instr),
        .ex_valid   (ex_valid),
        .md_busy_in (md_busy_in),
        .md_start   (md_start),
        .md_op      (md_op),
        .busy_o     (busy_o),
        .stall_d    (stall_d),
        .proto_err  (proto_err),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: samples outputs mid-cycle and compares against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("md_start", {31'd0, md_start}, {31'd0, e.start});
            if (e.start) chk("md_op", {30'd0, md_op}, {30'd0, e.op});
            chk("busy_o", {31'd0, busy_o}, {31'd0, e.busy});
            chk("stall_d", {31'd0, stall_d}, {31'd0, e.stall});
            chk("proto_err", {31'd0, proto_err}, {31'd0, e.perr});
            chk("stall_cnt", stall_cnt, e.cnt);
        end
    end

    // One clock cycle of stimulus plus the outputs expected during that cycle.
    task automatic cyc(input logic rst, input logic [31:0] id, input logic [31:0] ex,
                       input logic ev, input logic mbi,
                       input logic e_start, input logic [1:0] e_op, input logic e_busy,
                       input logic e_stall, input logic e_perr, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        id_instr   = id;
        ex_instr   = ex;
        ex_valid   = ev;
        md_busy_in = mbi;
        e.start = e_start; e.op = e_op; e.busy = e_busy;
        e.stall = e_stall; e.perr = e_perr; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        id_instr   = NOP;
        ex_instr   = NOP;
        ex_valid   = 1'b0;
        md_busy_in = 1'b0;
        repeat (2) @(posedge clk);

        // Reset cycle: a start in E and mflo in D are both suppressed.
        cyc(1, MFLO, MULT, 1, 0,  0, 0, 0, 0, 0, 0);

        // mult issue, 5 busy cycles, then idle.
        cyc(0, NOP, MULT, 1, 0,   1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, NOP, NOP, 0, 1,  0, 0, 1, 0, 0, 0);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 0, 0, 0, 0);

        // div with mflo held in D: 11 stall cycles, released on the 12th; busy mirrored.
        cyc(0, MFLO, DIVI, 1, 0,  1, 2, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) cyc(0, MFLO, NOP, 0, 1,  0, 0, 1, 1, 0, 32'(i));
        cyc(0, MFLO, NOP, 0, 0,   0, 0, 0, 0, 0, 11);

        // mult busy with addu in D: never stalled, counter unchanged.
        cyc(0, ADDU, MULT, 1, 0,  1, 0, 0, 0, 0, 11);
        for (int i = 0; i < 5; i++) cyc(0, ADDU, NOP, 0, 1,  0, 0, 1, 0, 0, 11);
        cyc(0, ADDU, NOP, 0, 0,   0, 0, 0, 0, 0, 11);

        // mult with ex_valid=0 is ignored.
        cyc(0, MFLO, MULT, 0, 0,  0, 0, 0, 0, 0, 11);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 0, 0, 0, 11);

        // multu forced into E during div: no start, sticky proto_err.
        cyc(0, NOP, DIVI, 1, 0,   1, 2, 0, 0, 0, 11);
        cyc(0, NOP, MULTU, 1, 1,  0, 0, 1, 0, 0, 11);
        for (int i = 0; i < 9; i++) cyc(0, NOP, NOP, 0, 1,  0, 0, 1, 0, 1, 11);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 0, 0, 1, 11);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 0, 0, 1, 11);

        // Reset clears the error and the stall counter.
        cyc(1, NOP, NOP, 0, 0,    0, 0, 0, 0, 1, 11);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 0, 0, 0, 0);

        // Reset at busy cycle 3 of a div, then a mult issues normally.
        cyc(0, MFLO, DIVI, 1, 0,  1, 2, 0, 1, 0, 0);
        cyc(0, MFLO, NOP, 0, 1,   0, 0, 1, 1, 0, 1);
        cyc(0, MFLO, NOP, 0, 1,   0, 0, 1, 1, 0, 2);
        cyc(1, MFLO, NOP, 0, 1,   0, 0, 0, 0, 0, 3);
        cyc(0, MFLO, NOP, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(0, MFLO, MULT, 1, 0,  1, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, MFLO, NOP, 0, 1,  0, 0, 1, 1, 0, 32'(i));
        cyc(0, MFLO, NOP, 0, 0,   0, 0, 0, 0, 0, 6);

        // Unit busy stuck low: first busy cycle tolerated, second flags the error.
        cyc(0, NOP, MULTU, 1, 0,  1, 1, 0, 0, 0, 6);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 1, 0, 0, 6);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 1, 0, 0, 6);
        for (int i = 0; i < 3; i++) cyc(0, NOP, NOP, 0, 0,  0, 0, 1, 0, 1, 6);
        cyc(0, NOP, NOP, 0, 0,    0, 0, 0, 0, 1, 6);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Issue and hazard controller for the pipeline's multiply/divide unit.
- Decodes the E-stage instruction and drives the unit's start pulse.
- Tracks unit occupancy with an internal latency counter.
- Stalls the D stage while a mult/div-class instruction would read or modify HI/LO before the unit is free.
- Sits between the hazard unit (D stage) and the mul/div unit (E stage), and keeps a stall-cycle performance counter.

Parameters:
MUL_CYCLES, 5, busy cycles after the start edge for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles after the start edge for div/divu (1..15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
id_instr  in  32  instruction currently in D stage
ex_instr  in  32  instruction currently in E stage
ex_valid  in  1  E-stage slot holds a real instruction (0 = bubble/flushed)
md_busy_in  in  1  busy flag from the mul/div unit (cross-check only)
md_start  out  1  one-cycle start pulse to the unit
md_op  out  2  0 mult, 1 multu, 2 div, 3 divu; meaningful only when md_start=1
busy_o  out  1  controller believes the unit is occupied
stall_d  out  1  freeze PC/D register, insert bubble into E
proto_err  out  1  sticky protocol violation flag
stall_cnt  out  32  count of cycles with stall_d=1

Behaviour:
- Decode, SPECIAL class (opcode [31:26]=0) only:
  - is_start: funct 011000, 011001, 011010, 011011.
  - is_md: is_start, or funct 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
- State machine, states IDLE / MUL / DIV, plus a 4-bit down-counter cnt.
- Reset values: IDLE, cnt=0, proto_err=0, stall_cnt=0. md_start, busy_o and stall_d are 0 during any reset cycle.
- md_start is combinational: !reset & ex_valid & is_start(ex_instr) & state==IDLE.
  - md_op = ex_instr[1:0].
- On an edge with md_start=1:
  - mult/multu: state<=MUL, cnt<=MUL_CYCLES.
  - div/divu: state<=DIV, cnt<=DIV_CYCLES.
- In MUL or DIV, each edge decrements cnt. At the edge where cnt==1: state<=IDLE, cnt<=0.
- busy_o = (state!=IDLE). It is high for exactly MUL_CYCLES or DIV_CYCLES cycles, starting the cycle after md_start. This matches the unit's busy window.
- stall_d = !reset & is_md(id_instr) & (md_start | busy_o).
  - Non-md instructions in D are never stalled by this block.
  - mfhi/mflo in D are released on the first cycle with busy_o=0 and md_start=0.
- stall_cnt increments on every edge where stall_d=1, wrapping 0xFFFFFFFF to 0.
- proto_err is set and held until reset when either:
  - ex_valid & is_start(ex_instr) & state!=IDLE (issue while occupied; md_start stays 0); or
  - busy_o != md_busy_in, sampled from the second cycle of an operation onward. The unit updates busy one edge late relative to the first cycle.
- Simultaneous events:
  - md_start in the same cycle that busy would end cannot occur (md_start requires IDLE).
  - A start in E with another md op in D: that cycle stalls D.
- Reset mid-operation returns to IDLE on that edge. The in-flight result is abandoned; the unit is reset by the same signal.
- ex_valid=0 suppresses md_start and the issue-while-busy check regardless of ex_instr.

Test Plan:
- Reset, then E=mult (0x00850018), ex_valid=1 -> md_start=1, md_op=0 in that cycle; busy_o=1 for the next 5 cycles, then 0.
- E=div (0x0085001A), D=mflo (0x00001012) held -> stall_d=1 on the issue cycle and for 10 busy cycles (11 total); stall_d=0 on cycle 12; stall_cnt=11.
- MUL busy, D=addu (0x00851021) -> stall_d=0 throughout, stall_cnt unchanged.
- Force E=multu with ex_valid=1 while in DIV -> md_start=0, proto_err=1 next cycle and held until reset.
- Assert reset at busy cycle 3 of a div -> next cycle busy_o=0, state IDLE, stall_cnt=0; a new mult issues normally.
- E=mult with ex_valid=0 -> md_start=0, busy_o stays 0; mirror md_busy_in against busy_o for a full div -> proto_err stays 0.
